// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the CPU memory bus initiator: state encodings,
// default bus widths and the values the block takes on reset.
package mem_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_HI = 2'd1,
        ST_ACC_LO = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_t;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic [15:0] RST_ADDRESS  = 16'h0000;
    localparam logic [7:0]  RST_DATA_OUT = 8'h00;
    localparam logic [15:0] RST_RDATA    = 16'h0000;

endpackage : mem_bus_master_pkg

// File: rtl/mem_bus_master.sv
// Initiator side of the CPU memory bus. Turns byte or 16-bit word requests
// into one or two byte cycles on an 8-bit memory with combinational read
// data and write-on-rising-edge. Words are big-endian: high byte at addr,
// low byte at addr+1 (wrapping modulo the address space).
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  wr,
    input  logic                  word,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic                  ready,
    output logic                  done,
    output logic [2*DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]     address,
    output logic                  write_en,
    output logic [DATA_W-1:0]     data_out,
    input  logic [DATA_W-1:0]     data_in
);

    bus_state_t            state, next_state;

    // Request fields latched on acceptance.
    logic                  wr_q, next_wr_q;
    logic                  word_q, next_word_q;
    logic [ADDR_W-1:0]     addr_q, next_addr_q;
    logic [2*DATA_W-1:0]   wdata_q, next_wdata_q;

    // Next values of the registered outputs.
    logic                  next_ready;
    logic                  next_done;
    logic [2*DATA_W-1:0]   next_rdata;
    logic [ADDR_W-1:0]     next_address;
    logic                  next_write_en;
    logic [DATA_W-1:0]     next_data_out;

    // Next-state and next-output logic; outputs for a cycle are computed
    // from the state being entered so that every port comes straight from a flop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        next_state    = state;
        next_wr_q     = wr_q;
        next_word_q   = word_q;
        next_addr_q   = addr_q;
        next_wdata_q  = wdata_q;
        next_rdata    = rdata;
        next_address  = address;
        next_data_out = data_out;
        next_write_en = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_wr_q     = wr;
                    next_word_q   = word;
                    next_addr_q   = addr;
                    next_wdata_q  = wdata;
                    next_address  = addr;
                    next_write_en = wr;
                    if (word) begin
                        next_state    = ST_ACC_HI;
                        next_data_out = wdata[2*DATA_W-1:DATA_W];
                    end else begin
                        next_state    = ST_ACC_LO;
                        next_data_out = wdata[DATA_W-1:0];
                    end
                end
            end
            ST_ACC_HI: begin
                if (!wr_q) begin
                    next_rdata[2*DATA_W-1:DATA_W] = data_in;
                end
                next_state    = ST_ACC_LO;
                next_address  = addr_q + ADDR_W'(1);
                next_data_out = wdata_q[DATA_W-1:0];
                next_write_en = wr_q;
            end
            ST_ACC_LO: begin
                if (!wr_q) begin
                    if (word_q) begin
                        next_rdata[DATA_W-1:0] = data_in;
                    end else begin
                        next_rdata = {{DATA_W{1'b0}}, data_in};
                    end
                end
                next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        next_ready = (next_state == ST_IDLE);
        next_done  = (next_state == ST_DONE);
    end

    // State, latched request and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state    <= ST_IDLE;
            wr_q     <= 1'b0;
            word_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            rdata    <= (2*DATA_W)'(RST_RDATA);
            address  <= ADDR_W'(RST_ADDRESS);
            write_en <= 1'b0;
            data_out <= DATA_W'(RST_DATA_OUT);
        end else begin
            state    <= next_state;
            wr_q     <= next_wr_q;
            word_q   <= next_word_q;
            addr_q   <= next_addr_q;
            wdata_q  <= next_wdata_q;
            ready    <= next_ready;
            done     <= next_done;
            rdata    <= next_rdata;
            address  <= next_address;
            write_en <= next_write_en;
            data_out <= next_data_out;
        end
    end

endmodule : mem_bus_master
